// File: rtl/mem_responder_pkg.sv
// ------------------------------------------------------------------
// mem_responder_pkg: shared state encoding and address constants
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_t;

  localparam logic [7:0] DEFAULT_IOADDR = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/mem_responder_byte_ram.sv
// ------------------------------------------------------------------
// byte_ram: one synchronous write port, one asynchronous read port
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module byte_ram #(
  parameter int WIDTH    = 8,
  parameter int ADDRBITS = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRBITS-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDRBITS-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDRBITS;

  // No reset: contents must survive a reset so a loaded program persists.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ------------------------------------------------------------------
// mem_responder: processor memory responder with host program loader
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               ADDRBITS = 8,
  parameter logic [WIDTH-1:0] IOADDR   = DEFAULT_IOADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             cpu_reset,
  output logic [WIDTH-1:0] io_out,
  output logic             io_strobe
);

  state_t              state, state_next;
  logic [ADDRBITS-1:0] ptr, ptr_next;
  logic                ram_we;
  logic [ADDRBITS-1:0] ram_waddr;
  logic [WIDTH-1:0]    ram_wdata;
  logic [WIDTH-1:0]    ram_rdata;
  logic                io_we;
  logic                is_io;

  assign is_io = (adr == IOADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      ptr       <= '0;
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      io_strobe <= io_we;
      if (io_we) begin
        io_out <= writedata;
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ram_we     = 1'b0;
    ram_waddr  = ptr;
    ram_wdata  = load_data;
    io_we      = 1'b0;
    case (state)
      ST_LOAD: begin
        if (load_valid) begin
          ram_we   = 1'b1;
          ptr_next = ptr + ADDRBITS'(1);
          if (load_last) begin
            state_next = ST_RELEASE;
          end
        end
        // A restart request dominates: the beat lands, then the load begins anew.
        if (load_start) begin
          ptr_next   = '0;
          state_next = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (memwrite) begin
          if (is_io) begin
            io_we = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = adr[ADDRBITS-1:0];
            ram_wdata = writedata;
          end
        end
        if (load_start) begin
          ptr_next   = '0;
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
        ptr_next   = '0;
      end
    endcase
  end

  assign load_ready = (state == ST_LOAD);
  assign cpu_reset  = (state != ST_RUN);

  // Read port shows pre-write contents when a write targets the same address.
  always_comb begin
    memdata = '0;
    if ((state == ST_RUN) && memread) begin
      memdata = is_io ? io_out : ram_rdata;
    end
  end

  byte_ram #(
    .WIDTH   (WIDTH),
    .ADDRBITS(ADDRBITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(adr[ADDRBITS-1:0]),
    .rdata(ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ------------------------------------------------------------------
// tb_mem_responder: scoreboard bench with a behavioural memory model
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] memdata;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       cpu_reset;
  logic [7:0] io_out;
  logic       io_strobe;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .cpu_reset (cpu_reset),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a byte array, a load pointer and the output register.
  logic [7:0] model_ram [256];
  logic [7:0] model_io = 8'h00;
  int         model_ptr = 0;
  bit         loading = 1'b1;
  bit         running = 1'b0;
  bit         mon_en = 1'b0;

  logic [7:0] rd_q [$];
  logic [7:0] io_q [$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (memread) begin
        if (rd_q.size() == 0) chk("memdata_unexpected_read", 1, 0);
        else chk("memdata", memdata, rd_q.pop_front());
      end else begin
        chk("memdata_idle", memdata, 0);
      end
      if (io_strobe) begin
        if (io_q.size() == 0) chk("io_strobe_unexpected", 1, 0);
        else chk("io_out", io_out, io_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [7:0] d, input bit last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (loading) begin
      model_ram[model_ptr] = d;
      model_ptr = (model_ptr + 1) % 256;
    end
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic load_last_and_release(input logic [7:0] d);
    load_beat(d, 1'b1);
    chk("release_cpu_reset", cpu_reset, 1);
    chk("release_load_ready", load_ready, 0);
    loading = 1'b0;
    step();
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_load_ready", load_ready, 0);
    running = 1'b1;
  endtask

  task automatic cpu_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    memread   = rd;
    memwrite  = wr;
    adr       = a;
    writedata = wd;
    if (rd) rd_q.push_back(!running ? 8'h00 : (a == 8'hFF ? model_io : model_ram[a]));
    if (wr && running) begin
      if (a == 8'hFF) begin
        model_io = wd;
        io_q.push_back(wd);
      end else begin
        model_ram[a] = wd;
      end
    end
    step();
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic restart(input bit with_valid);
    load_start = 1'b1;
    load_valid = with_valid;
    load_data  = 8'hEE;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    running   = 1'b0;
    loading   = 1'b1;
    model_ptr = 0;
    chk("restart_cpu_reset", cpu_reset, 1);
    chk("restart_load_ready", load_ready, 1);
  endtask

  task automatic sweep();
    for (int a = 0; a < 255; a++) cpu_access(1'b1, 1'b0, 8'(a), 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("reset_memdata", memdata, 0);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_cpu_reset", cpu_reset, 1);
    chk("reset_io_out", io_out, 0);
    chk("reset_io_strobe", io_strobe, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Short program: processor stays in reset until two edges after the last beat.
    load_beat(8'h80, 1'b0);
    load_beat(8'h01, 1'b0);
    load_beat(8'h02, 1'b0);
    chk("load_cpu_reset_held", cpu_reset, 1);
    load_last_and_release(8'h03);
    cpu_access(1'b1, 1'b0, 8'h02, 8'h00);
    step();
    for (int a = 0; a < 4; a++) cpu_access(1'b1, 1'b0, 8'(a), 8'h00);

    // 257-byte load: the pointer wraps and byte 256 overwrites address 0.
    restart(1'b0);
    for (int i = 0; i < 256; i++) load_beat(8'(i) ^ 8'h55, 1'b0);
    load_last_and_release(8'h55);
    sweep();

    // Output register write, strobe, read-back; RAM behind it untouched.
    cpu_access(1'b0, 1'b1, 8'hFF, 8'h5A);
    step();
    cpu_access(1'b1, 1'b0, 8'hFF, 8'h00);
    chk("ram_ff_untouched", dut.u_ram.mem[255], model_ram[255]);
    cpu_access(1'b1, 1'b1, 8'h10, 8'hC3);
    cpu_access(1'b1, 1'b0, 8'h10, 8'h00);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cpu_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // Restart in RUN with a beat offered the same cycle: that beat is dropped.
    restart(1'b1);
    load_beat(8'h11, 1'b0);
    load_beat(8'h22, 1'b0);
    load_last_and_release(8'h33);
    sweep();

    // Reset in the middle of a load: pointer and output register clear, RAM kept.
    restart(1'b0);
    load_beat(8'hA1, 1'b0);
    load_beat(8'hA2, 1'b0);
    load_beat(8'hA3, 1'b0);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    model_ptr = 0;
    model_io  = 8'h00;
    chk("midload_reset_io_out", io_out, 0);
    chk("midload_reset_cpu_reset", cpu_reset, 1);
    chk("midload_reset_load_ready", load_ready, 1);
    load_last_and_release(8'hB0);
    sweep();
    cpu_access(1'b1, 1'b0, 8'hFF, 8'h00);

    step();
    step();
    chk("read_queue_drained", rd_q.size(), 0);
    chk("io_queue_drained", io_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
